// File: rtl/core_bus_arbiter.sv
//==============================================================================
// Module   : core_bus_arbiter
// Purpose  : Shares one pipelined Wishbone slave port between the CPU ibus
//            and dbus masters. One master owns the slave for the full length
//            of its cycle; an outstanding-request counter makes sure every
//            ack is routed back to the master that issued the request.
// Options  : CORE_ARB_RR_EN - round-robin tie break in IDLE (default build
//            uses fixed dbus priority).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module core_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            rst,      // asynchronous, active-low

    // Instruction master
    input  logic            i_cyc,
    input  logic            i_stb,
    input  logic [AW-1:0]   i_adr,
    output logic            i_stall,
    output logic            i_ack,
    output logic [DW-1:0]   i_dat_o,

    // Data master
    input  logic            d_cyc,
    input  logic            d_stb,
    input  logic            d_we,
    input  logic [AW-1:0]   d_adr,
    input  logic [DW/8-1:0] d_sel,
    input  logic [DW-1:0]   d_dat_i,
    output logic            d_stall,
    output logic            d_ack,
    output logic [DW-1:0]   d_dat_o,

    // Shared slave
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW/8-1:0] s_sel,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_stall,
    input  logic            s_ack,
    input  logic [DW-1:0]   s_dat_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_I = 2'd1;
    localparam logic [1:0] S_GNT_D = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [3:0] CNT_MAX = 4'(MAX_OUT);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       gnt_i, gnt_d;
    logic       full;
    logic       accept;
    logic       ack_valid;
    logic       pick_d;

    assign gnt_i = (state_q == S_GNT_I);
    assign gnt_d = (state_q == S_GNT_D);

    // Window is full unless an ack this cycle frees a slot.
    assign full      = (cnt_q == CNT_MAX) && !s_ack;
    // An ack with nothing outstanding is a protocol error and is dropped.
    assign ack_valid = s_ack && (cnt_q != 4'd0);
    assign accept    = s_stb && !s_stall;

`ifdef CORE_ARB_RR_EN
    logic last_d_q;   // 1 = dbus was the most recent owner

    assign pick_d = d_cyc && (!i_cyc || !last_d_q);

    // Remember who was granted last so a tie alternates between masters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_q <= 1'b1;
        end else if ((state_q == S_IDLE) && (i_cyc || d_cyc)) begin
            last_d_q <= pick_d;
        end
    end
`else
    assign pick_d = d_cyc;
`endif

    // Slave-side request mux and master-side stall/ack/data routing.
    always_comb begin
        s_cyc   = (state_q != S_IDLE);
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_sel   = '0;
        s_dat_o = '0;
        i_stall = 1'b1;
        d_stall = 1'b1;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        i_dat_o = '0;
        d_dat_o = '0;
        if (gnt_i) begin
            s_stb   = i_cyc && i_stb && !full;
            s_adr   = i_adr;
            s_sel   = '1;
            i_stall = s_stall || full;
            i_ack   = ack_valid;
            i_dat_o = s_dat_i;
        end else if (gnt_d) begin
            s_stb   = d_cyc && d_stb && !full;
            s_we    = d_we;
            s_adr   = d_adr;
            s_sel   = d_sel;
            s_dat_o = d_dat_i;
            d_stall = s_stall || full;
            d_ack   = ack_valid;
            d_dat_o = s_dat_i;
        end
    end

    // Outstanding count and next-state selection.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !ack_valid) begin
            cnt_d = cnt_q + 4'd1;
        end else if (!accept && ack_valid) begin
            cnt_d = cnt_q - 4'd1;
        end

        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pick_d) begin
                    state_d = S_GNT_D;
                end else if (i_cyc) begin
                    state_d = S_GNT_I;
                end
            end
            S_GNT_I: begin
                if (!i_cyc) begin
                    state_d = (cnt_d == 4'd0) ? S_IDLE : S_DRAIN;
                end
            end
            S_GNT_D: begin
                if (!d_cyc) begin
                    state_d = (cnt_d == 4'd0) ? S_IDLE : S_DRAIN;
                end
            end
            default: begin
                if (cnt_d == 4'd0) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire
